// File: rtl/common_pkg.sv
// Shared types used across the debug-side blocks.
package common_pkg;

    // Single-bit DM-facing handshake/status signal.
    typedef enum logic {
        SIG_LOW  = 1'b0,
        SIG_HIGH = 1'b1
    } onebit_sig_e;

endpackage

// File: rtl/debug_pkg.sv
// Types for the debug module's abstract memory-access path.
package debug_pkg;

    // Access size encoding on am_st_i; every other value is illegal.
    typedef enum logic [3:0] {
        AM_SIZE_B = 4'd0,
        AM_SIZE_H = 4'd1,
        AM_SIZE_W = 4'd2
    } am_size_e;

    // Request sequencing through the data-memory port.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } am_state_e;

endpackage

// File: rtl/dm_mem_lane.sv
// Byte-lane steering for a 32-bit little-endian data port: byte enables,
// write-data replication, read-data extraction and alignment checking.
// Purely combinational so it can be shared with a system-bus access path.
module dm_mem_lane
    import debug_pkg::*;
(
    input  logic [3:0]  size,
    input  logic [1:0]  ad,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        illegal
);

    logic [31:0] shifted;

    // Shift the addressed lane down to bit 0; the size masks it afterwards.
    assign shifted = rdata >> {ad, 3'b000};

    // Decode size and offset into lane controls.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        be        = 4'b0000;
        wdata_rep = 32'h0;
        rdata_ext = 32'h0;
        illegal   = 1'b0;
        case (size)
            AM_SIZE_B: begin
                be        = 4'b0001 << ad;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {24'h0, shifted[7:0]};
            end
            AM_SIZE_H: begin
                be        = 4'b0011 << ad;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {16'h0, shifted[15:0]};
                illegal   = ad[0];
            end
            AM_SIZE_W: begin
                be        = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = shifted;
                illegal   = (ad != 2'b00);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/dm_mem_access.sv
// Hart-side responder for the debug module's abstract memory access.
// Turns one am_* request into one req/gnt/rvalid transaction and returns
// right-aligned read data with a one-cycle done pulse.
// Optional: define DM_MEM_TIMEOUT_EN to abandon a request that is not
// granted within TIMEOUT_CYCLES cycles (reported as an error).
module dm_mem_access
    import common_pkg::*;
    import debug_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)(
    input  logic        clk_i,
    input  logic        rst_i,
    input  onebit_sig_e am_en_i,
    input  onebit_sig_e am_wr_i,
    input  logic [3:0]  am_st_i,
    input  logic [31:0] am_ad_i,
    input  logic [31:0] am_do_i,
    output logic [31:0] am_di_o,
    output onebit_sig_e am_done_o,
    output onebit_sig_e am_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i
);

    if (TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    am_state_e   state_q, state_d;
    logic        wr_q;
    logic [3:0]  size_q;
    logic [1:0]  ad_lo_q;
    logic [3:0]  lane_size;
    logic [1:0]  lane_ad;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;
    logic        lane_illegal;
    logic        timeout;

    // In IDLE the lane logic looks at the live request; afterwards at the capture.
    assign lane_size = (state_q == IDLE) ? am_st_i        : size_q;
    assign lane_ad   = (state_q == IDLE) ? am_ad_i[1:0]   : ad_lo_q;

    dm_mem_lane u_lane (
        .size      (lane_size),
        .ad        (lane_ad),
        .wdata     (am_do_i),
        .rdata     (mem_rdata_i),
        .be        (lane_be),
        .wdata_rep (lane_wdata),
        .rdata_ext (lane_rdata),
        .illegal   (lane_illegal)
    );

`ifdef DM_MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] wait_cnt_q;

    // Count ungranted REQ cycles; any other state clears, so each REQ entry starts at 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_cnt_q <= '0;
        end else if (state_q != REQ) begin
            wait_cnt_q <= '0;
        end else if (!mem_gnt_i) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end

    assign timeout = (state_q == REQ) && !mem_gnt_i &&
                     (32'(wait_cnt_q) == TIMEOUT_CYCLES - 32'd1);
`else
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop sees pre-edge values.
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (am_en_i == SIG_HIGH) state_d = lane_illegal ? DONE : REQ;
            REQ: begin
                if (mem_gnt_i)    state_d = RESP;
                else if (timeout) state_d = DONE;
            end
            RESP: if (mem_rvalid_i) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs and request capture.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q        <= 1'b0;
            size_q      <= 4'h0;
            ad_lo_q     <= 2'b00;
            am_di_o     <= 32'h0;
            am_done_o   <= SIG_LOW;
            am_err_o    <= SIG_LOW;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= 4'b0000;
            mem_addr_o  <= 32'h0;
            mem_wdata_o <= 32'h0;
        end else begin
            am_done_o <= SIG_LOW;
            case (state_q)
                IDLE: begin
                    if (am_en_i == SIG_HIGH) begin
                        wr_q    <= (am_wr_i == SIG_HIGH);
                        size_q  <= am_st_i;
                        ad_lo_q <= am_ad_i[1:0];
                        am_di_o <= 32'h0;
                        if (lane_illegal) begin
                            am_err_o  <= SIG_HIGH;
                            am_done_o <= SIG_HIGH;
                        end else begin
                            am_err_o    <= SIG_LOW;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= (am_wr_i == SIG_HIGH);
                            mem_be_o    <= lane_be;
                            mem_addr_o  <= {am_ad_i[31:2], 2'b00};
                            mem_wdata_o <= lane_wdata;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                    end else if (timeout) begin
                        mem_req_o <= 1'b0;
                        am_err_o  <= SIG_HIGH;
                        am_di_o   <= 32'h0;
                        am_done_o <= SIG_HIGH;
                    end
                end
                RESP: begin
                    if (mem_rvalid_i) begin
                        am_done_o <= SIG_HIGH;
                        am_err_o  <= onebit_sig_e'(mem_err_i);
                        am_di_o   <= wr_q ? 32'h0 : lane_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_mem_access.sv
// Self-checking bench for dm_mem_access: directed cases plus randomized
// accesses checked against a byte-level reference model.
module tb_dm_mem_access;
    import common_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    onebit_sig_e am_en_i = SIG_LOW;
    onebit_sig_e am_wr_i = SIG_LOW;
    logic [3:0]  am_st_i = 4'h0;
    logic [31:0] am_ad_i = 32'h0;
    logic [31:0] am_do_i = 32'h0;
    logic [31:0] am_di_o;
    onebit_sig_e am_done_o;
    onebit_sig_e am_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'h0;
    logic        mem_err_i = 1'b0;

    int checks = 0;
    int errors = 0;

    dm_mem_access #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .am_en_i      (am_en_i),
        .am_wr_i      (am_wr_i),
        .am_st_i      (am_st_i),
        .am_ad_i      (am_ad_i),
        .am_do_i      (am_do_i),
        .am_di_o      (am_di_o),
        .am_done_o    (am_done_o),
        .am_err_o     (am_err_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .mem_err_i    (mem_err_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Byte-level reference: size in bytes, naturally aligned, little-endian lanes.
    function automatic void model(input logic [3:0] st, input logic [31:0] ad,
                                  input logic [31:0] d, input logic [31:0] rdata,
                                  output bit legal, output logic [3:0] be,
                                  output logic [31:0] wd, output logic [31:0] rd);
        int n;
        int off;
        n   = (st == 4'd0) ? 1 : (st == 4'd1) ? 2 : (st == 4'd2) ? 4 : 0;
        off = int'(ad[1:0]);
        be  = 4'b0000;
        wd  = 32'h0;
        rd  = 32'h0;
        legal = (n != 0) && ((off % n) == 0);
        if (legal) begin
            for (int i = 0; i < n; i++) begin
                be[off + i]   = 1'b1;
                rd[8*i +: 8]  = rdata[8*(off + i) +: 8];
            end
            for (int k = 0; k < 4; k++) wd[8*k +: 8] = d[8*(k % n) +: 8];
        end
    endfunction

    // One full access from the debug-module side with a scripted bus responder.
    // lat: expected negedges until req or done appears (2 when en was held over DONE).
    task automatic do_access(input string name, input logic wr, input logic [3:0] st,
                             input logic [31:0] ad, input logic [31:0] d,
                             input int gnt_dly, input int rv_dly,
                             input logic [31:0] rdata, input logic berr,
                             input int lat, input bit hold_en);
        bit          legal;
        logic [3:0]  be;
        logic [31:0] wd, rd, exp_di;
        int          cyc;
        model(st, ad, d, rdata, legal, be, wd, rd);
        exp_di = wr ? 32'h0 : rd;
        am_en_i = SIG_HIGH;
        am_wr_i = onebit_sig_e'(wr);
        am_st_i = st;
        am_ad_i = ad;
        am_do_i = d;
        cyc = 0;
        do begin
            @(negedge clk_i);
            cyc++;
        end while (!(mem_req_o || am_done_o == SIG_HIGH) && cyc < 8);
        checks++;
        if (cyc !== lat) begin
            errors++;
            $display("FAIL %s accept_latency got=%0d exp=%0d", name, cyc, lat);
        end
        if (!legal) begin
            checks++;
            if ({mem_req_o, am_done_o, am_err_o, am_di_o} !== {1'b0, SIG_HIGH, SIG_HIGH, 32'h0}) begin
                errors++;
                $display("FAIL %s illegal_done got req=%b done=%b err=%b di=%h exp req=0 done=1 err=1 di=0",
                         name, mem_req_o, am_done_o, am_err_o, am_di_o);
            end
        end else begin
            // Captured inputs must be ignored from here on.
            am_wr_i = onebit_sig_e'($urandom_range(0, 1));
            am_st_i = 4'($urandom);
            am_ad_i = $urandom;
            am_do_i = $urandom;
            for (int s = 0; s <= gnt_dly; s++) begin
                if (s > 0) @(negedge clk_i);
                checks++;
                if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !==
                    {1'b1, wr, be, {ad[31:2], 2'b00}, wd}) begin
                    errors++;
                    $display("FAIL %s req_fields cyc=%0d got req=%b we=%b be=%b addr=%h wdata=%h exp req=1 we=%b be=%b addr=%h wdata=%h",
                             name, s, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
                             wr, be, {ad[31:2], 2'b00}, wd);
                end
            end
            mem_gnt_i = 1'b1;
            @(negedge clk_i);
            mem_gnt_i = 1'b0;
            checks++;
            if (mem_req_o !== 1'b0) begin
                errors++;
                $display("FAIL %s req_drop got=%b exp=0", name, mem_req_o);
            end
            for (int r = 0; r < rv_dly; r++) @(negedge clk_i);
            checks++;
            if (am_done_o !== SIG_LOW) begin
                errors++;
                $display("FAIL %s early_done got=%b exp=0", name, am_done_o);
            end
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = rdata;
            mem_err_i    = berr;
            @(negedge clk_i);
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = $urandom;
            mem_err_i    = 1'b0;
            checks++;
            if ({am_done_o, am_err_o, am_di_o} !== {SIG_HIGH, onebit_sig_e'(berr), exp_di}) begin
                errors++;
                $display("FAIL %s done_data got done=%b err=%b di=%h exp done=1 err=%b di=%h",
                         name, am_done_o, am_err_o, am_di_o, berr, exp_di);
            end
        end
        if (!hold_en) begin
            am_en_i = SIG_LOW;
            @(negedge clk_i);
            checks++;
            if ({am_done_o, am_di_o, mem_req_o} !== {SIG_LOW, legal ? exp_di : 32'h0, 1'b0}) begin
                errors++;
                $display("FAIL %s done_pulse_hold got done=%b di=%h req=%b exp done=0 di=%h req=0",
                         name, am_done_o, am_di_o, mem_req_o, legal ? exp_di : 32'h0);
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        checks++;
        if ({am_di_o, am_done_o, am_err_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got di=%h done=%b err=%b req=%b we=%b be=%b addr=%h wdata=%h exp all zero",
                     am_di_o, am_done_o, am_err_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o);
        end
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_directed();
        do_access("word_read",  1'b0, 4'd2, 32'h100, 32'h0,        0, 0, 32'hDEADBEEF, 1'b0, 1, 1'b0);
        do_access("byte_write", 1'b1, 4'd0, 32'h203, 32'h000000A5, 0, 0, 32'h0,        1'b0, 1, 1'b0);
        do_access("half_read",  1'b0, 4'd1, 32'h102, 32'h0,        0, 0, 32'h12345678, 1'b0, 1, 1'b0);
        do_access("word_misal", 1'b0, 4'd2, 32'h101, 32'h0,        0, 0, 32'h0,        1'b0, 1, 1'b0);
        do_access("size3",      1'b1, 4'd3, 32'h100, 32'h55,       0, 0, 32'h0,        1'b0, 1, 1'b0);
        do_access("half_odd",   1'b0, 4'd1, 32'h103, 32'h0,        0, 0, 32'h0,        1'b0, 1, 1'b0);
        do_access("gnt_stall",  1'b0, 4'd2, 32'h80,  32'h0,        3, 1, 32'hCAFEF00D, 1'b1, 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_access("b2b_illegal", 1'b0, 4'd2, 32'h101, 32'h0,      0, 0, 32'h0,        1'b0, 1, 1'b1);
        do_access("b2b_read",    1'b0, 4'd2, 32'h300, 32'h0,      0, 0, 32'h0BADC0DE, 1'b0, 2, 1'b1);
        do_access("b2b_write",   1'b1, 4'd1, 32'h306, 32'hBEEF,   1, 0, 32'h0,        1'b0, 2, 1'b0);
    endtask

    task automatic test_reset_mid_op();
        am_en_i = SIG_HIGH;
        am_wr_i = SIG_LOW;
        am_st_i = 4'd2;
        am_ad_i = 32'h400;
        @(negedge clk_i);
        mem_gnt_i = 1'b1;
        @(negedge clk_i);
        mem_gnt_i = 1'b0;
        rst_i = 1'b1;
        #1;
        checks++;
        if ({mem_req_o, am_done_o} !== {1'b0, SIG_LOW}) begin
            errors++;
            $display("FAIL rst_mid_op got req=%b done=%b exp req=0 done=0", mem_req_o, am_done_o);
        end
        @(negedge clk_i);
        am_en_i = SIG_LOW;
        rst_i = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h11111111;
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({mem_req_o, am_done_o} !== {1'b0, SIG_LOW}) begin
                errors++;
                $display("FAIL late_rvalid cyc=%0d got req=%b done=%b exp req=0 done=0", i, mem_req_o, am_done_o);
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_random();
        bit hold;
        bit prev_hold = 1'b0;
        int r;
        logic [3:0] st;
        for (int i = 0; i < 60; i++) begin
            r    = int'($urandom_range(0, 5));
            st   = (r <= 2) ? 4'(r) : 4'($urandom_range(3, 15));
            hold = (i < 59) && ($urandom_range(0, 3) == 0);
            do_access("rand", 1'($urandom_range(0, 1)), st, $urandom, $urandom,
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), $urandom,
                      ($urandom_range(0, 3) == 0), prev_hold ? 2 : 1, hold);
            prev_hold = hold;
        end
    endtask

`ifdef DM_MEM_TIMEOUT_EN
    task automatic test_timeout();
        int high_cycles;
        am_en_i = SIG_HIGH;
        am_wr_i = SIG_HIGH;
        am_st_i = 4'd2;
        am_ad_i = 32'h500;
        am_do_i = 32'h12345678;
        high_cycles = 0;
        @(negedge clk_i);
        while (mem_req_o && high_cycles < 10) begin
            high_cycles++;
            @(negedge clk_i);
        end
        checks++;
        if (high_cycles !== 4) begin
            errors++;
            $display("FAIL timeout_req_cycles got=%0d exp=4", high_cycles);
        end
        checks++;
        if ({am_done_o, am_err_o, am_di_o} !== {SIG_HIGH, SIG_HIGH, 32'h0}) begin
            errors++;
            $display("FAIL timeout_done got done=%b err=%b di=%h exp done=1 err=1 di=0",
                     am_done_o, am_err_o, am_di_o);
        end
        am_en_i = SIG_LOW;
        @(negedge clk_i);
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
`ifdef DM_MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
